// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-transfer memory bus between the I-cache and D-cache miss paths.
// One transaction at a time: IDLE grants, BUSY holds the strobe until mem_ready, RESP pulses the requester's ready.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_mem_read,
    input  logic [ADDR_W-1:0] ic_mem_addr,
    output logic [DATA_W-1:0] ic_mem_rdata,
    output logic              ic_mem_ready,
    input  logic              dc_mem_read,
    input  logic              dc_mem_write,
    input  logic [ADDR_W-1:0] dc_mem_addr,
    input  logic [DATA_W-1:0] dc_mem_wdata,
    output logic [DATA_W-1:0] dc_mem_rdata,
    output logic              dc_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    logic [1:0]        state_q,     state_d;
    logic              last_gnt_q,  last_gnt_d;
    logic              gnt_q,       gnt_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] ic_rdata_q,  ic_rdata_d;
    logic [DATA_W-1:0] dc_rdata_q,  dc_rdata_d;
    logic              ic_ready_q,  ic_ready_d;
    logic              dc_ready_q,  dc_ready_d;

    logic ic_req;
    logic dc_req;
    logic gnt_sel;

    assign ic_req = ic_mem_read;
    assign dc_req = dc_mem_read | dc_mem_write;

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        gnt_d       = gnt_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ic_rdata_d  = ic_rdata_q;
        dc_rdata_d  = dc_rdata_q;
        ic_ready_d  = 1'b0;
        dc_ready_d  = 1'b0;
        gnt_sel     = PORT_I;

        case (state_q)
            IDLE: begin
                if (ic_req || dc_req) begin
                    if (ic_req && dc_req) begin
                        gnt_sel = (last_gnt_q == PORT_I) ? PORT_D : PORT_I;
                    end else begin
                        gnt_sel = dc_req ? PORT_D : PORT_I;
                    end
                    last_gnt_d = gnt_sel;
                    gnt_d      = gnt_sel;
                    state_d    = BUSY;
                    // A D-side read+write collision issues the write; the cache replays the read later.
                    if (gnt_sel == PORT_D) begin
                        mem_write_d = dc_mem_write;
                        mem_read_d  = ~dc_mem_write;
                        mem_addr_d  = dc_mem_addr;
                        mem_wdata_d = dc_mem_wdata;
                    end else begin
                        mem_write_d = 1'b0;
                        mem_read_d  = 1'b1;
                        mem_addr_d  = ic_mem_addr;
                    end
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = RESP;
                    if (gnt_q == PORT_D) begin
                        dc_ready_d = 1'b1;
                        if (mem_read_q) dc_rdata_d = mem_rdata;
                    end else begin
                        ic_ready_d = 1'b1;
                        if (mem_read_q) ic_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset abandons any in-flight transfer; a late mem_ready then lands in IDLE and is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_gnt_q  <= PORT_D;
            gnt_q       <= PORT_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
            ic_ready_q  <= 1'b0;
            dc_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            gnt_q       <= gnt_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ic_rdata_q  <= ic_rdata_d;
            dc_rdata_q  <= dc_rdata_d;
            ic_ready_q  <= ic_ready_d;
            dc_ready_q  <= dc_ready_d;
        end
    end

    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign ic_mem_rdata = ic_rdata_q;
    assign dc_mem_rdata = dc_rdata_q;
    assign ic_mem_ready = ic_ready_q;
    assign dc_mem_ready = dc_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: fixed vectors, hand-written corner sequences and randomized traffic
// checked against a transaction-level model of round-robin arbitration and per-port read data.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_mem_read;
    logic [27:0]  ic_mem_addr;
    logic [127:0] ic_mem_rdata;
    logic         ic_mem_ready;
    logic         dc_mem_read;
    logic         dc_mem_write;
    logic [27:0]  dc_mem_addr;
    logic [127:0] dc_mem_wdata;
    logic [127:0] dc_mem_rdata;
    logic         dc_mem_ready;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: who won the last grant (1 = D) and what each port should currently show.
    logic         model_last;
    logic [127:0] exp_ic_rdata;
    logic [127:0] exp_dc_rdata;

    typedef struct {
        logic         ic_r;
        logic         dc_r;
        logic         dc_w;
        logic [27:0]  addr;
        logic [127:0] wdata;
        int           lat;
        logic [127:0] ret;
        logic         exp_d;
        logic         exp_wr;
    } vec_t;

    vec_t vecs[5];

    mem_arbiter #(.ADDR_W(28), .DATA_W(128)) dut (
        .clk          (clk),
        .rst          (rst),
        .ic_mem_read  (ic_mem_read),
        .ic_mem_addr  (ic_mem_addr),
        .ic_mem_rdata (ic_mem_rdata),
        .ic_mem_ready (ic_mem_ready),
        .dc_mem_read  (dc_mem_read),
        .dc_mem_write (dc_mem_write),
        .dc_mem_addr  (dc_mem_addr),
        .dc_mem_wdata (dc_mem_wdata),
        .dc_mem_rdata (dc_mem_rdata),
        .dc_mem_ready (dc_mem_ready),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check_output({name, " mem_read"},  mem_read,  0);
        check_output({name, " mem_write"}, mem_write, 0);
        check_output({name, " mem_addr"},  mem_addr,  0);
        check_output({name, " mem_wdata"}, mem_wdata, 0);
        check_output({name, " ready"},     {ic_mem_ready, dc_mem_ready}, 0);
        check_output({name, " ic_rdata"},  ic_mem_rdata, 0);
        check_output({name, " dc_rdata"},  dc_mem_rdata, 0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        ic_mem_read  = v.ic_r;
        dc_mem_read  = v.dc_r;
        dc_mem_write = v.dc_w;
        ic_mem_addr  = v.addr;
        dc_mem_addr  = v.addr;
        dc_mem_wdata = v.wdata;
    endtask

    // Called in an IDLE cycle with requests already driven; returns in the cycle after the ready pulse.
    task automatic serve(input string name, input logic exp_d, input logic exp_wr,
                         input logic [27:0] exp_addr, input logic [127:0] exp_wdata,
                         input int lat, input logic [127:0] ret);
        @(posedge clk); #1;
        check_output({name, " addr"}, mem_addr, exp_addr);
        if (exp_wr) check_output({name, " wdata"}, mem_wdata, exp_wdata);
        for (int k = 1; k <= lat; k++) begin
            check_output({name, " mem_read"},  mem_read,  !exp_wr);
            check_output({name, " mem_write"}, mem_write, exp_wr);
            check_output({name, " early ready"}, {ic_mem_ready, dc_mem_ready}, 0);
            if (k == lat) begin
                mem_ready = 1'b1;
                mem_rdata = ret;
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
            mem_rdata = ~ret;
        end
        if (!exp_wr) begin
            if (exp_d) exp_dc_rdata = ret;
            else       exp_ic_rdata = ret;
        end
        model_last = exp_d;
        check_output({name, " strobe drop"}, {mem_read, mem_write}, 0);
        check_output({name, " ready pulse"}, {ic_mem_ready, dc_mem_ready}, {!exp_d, exp_d});
        check_output({name, " ic_rdata"}, ic_mem_rdata, exp_ic_rdata);
        check_output({name, " dc_rdata"}, dc_mem_rdata, exp_dc_rdata);
        @(posedge clk); #1;
        if (exp_d) begin
            dc_mem_read  = 1'b0;
            dc_mem_write = 1'b0;
        end else begin
            ic_mem_read = 1'b0;
        end
        check_output({name, " ready end"}, {ic_mem_ready, dc_mem_ready}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_last   = 1'b1;
        exp_ic_rdata = '0;
        exp_dc_rdata = '0;
    endtask

    initial begin
        logic ic_pend, d_pend, gnt_d, just_d, just_i;
        int   d_op;

        rst = 1'b1; ic_mem_read = 0; dc_mem_read = 0; dc_mem_write = 0;
        ic_mem_addr = '0; dc_mem_addr = '0; dc_mem_wdata = '0;
        mem_rdata = '0; mem_ready = 0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 28'h0000010, 128'h0, 3,
                    128'h0123456789ABCDEF0123456789ABCDEF, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 28'h0000020, {32{4'hA}}, 2, 128'h0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 28'h0000040, 128'h0, 1, {32{4'h5}}, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 28'h0000060, 128'h1234, 2, 128'hDEAD, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 28'hFFFFFFF, 128'h0, 1, {128{1'b1}}, 1'b0, 1'b0};

        do_reset();
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Tie straight after reset goes to I, then the waiting D.
        ic_mem_read = 1; ic_mem_addr = 28'h100;
        dc_mem_read = 1; dc_mem_addr = 28'h200;
        serve("pair1 I", 1'b0, 1'b0, 28'h100, 128'h0, 2, 128'h11);
        serve("pair1 D", 1'b1, 1'b0, 28'h200, 128'h0, 1, 128'h22);

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i]);
            serve($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_wr, vecs[i].addr,
                  vecs[i].wdata, vecs[i].lat, vecs[i].ret);
        end

        // Last grant was I, so this tie goes to D first.
        ic_mem_read = 1; ic_mem_addr = 28'h300;
        dc_mem_read = 1; dc_mem_addr = 28'h400;
        serve("pair2 D", 1'b1, 1'b0, 28'h400, 128'h0, 2, 128'h44);
        serve("pair2 I", 1'b0, 1'b0, 28'h300, 128'h0, 1, 128'h33);

        ic_mem_read = 1; ic_mem_addr = 28'h500;
        @(posedge clk); #1;
        check_output("midbusy strobe", mem_read, 1);
        rst = 1'b1; ic_mem_read = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_last = 1'b1; exp_ic_rdata = '0; exp_dc_rdata = '0;
        check_all_zero("midbusy reset");
        mem_ready = 1; mem_rdata = 128'hBAD;
        @(posedge clk); #1;
        mem_ready = 0;
        check_all_zero("late mem_ready");
        @(posedge clk); #1;
        check_all_zero("late mem_ready +1");

        mem_ready = 1; mem_rdata = rand128();
        @(posedge clk); #1;
        mem_ready = 0;
        @(posedge clk); #1;
        check_all_zero("spurious mem_ready");

        ic_pend = 0; d_pend = 0; just_d = 0; just_i = 0;
        for (int it = 0; it < 60; it++) begin
            if (!ic_pend && !just_i && $urandom_range(0, 1) == 1) begin
                ic_pend = 1; ic_mem_read = 1; ic_mem_addr = 28'($urandom);
            end
            if (!d_pend && !just_d && $urandom_range(0, 1) == 1) begin
                d_pend = 1;
                d_op = int'($urandom_range(0, 2));
                dc_mem_read  = (d_op != 1);
                dc_mem_write = (d_op != 0);
                dc_mem_addr  = 28'($urandom);
                dc_mem_wdata = rand128();
            end
            just_d = 0; just_i = 0;
            if (!ic_pend && !d_pend) begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = rand128();
                @(posedge clk); #1;
                mem_ready = 0;
                check_output("rand idle strobe", {mem_read, mem_write}, 0);
                check_output("rand idle ready", {ic_mem_ready, dc_mem_ready}, 0);
                continue;
            end
            if (ic_pend && d_pend) gnt_d = !model_last;
            else                   gnt_d = d_pend;
            serve($sformatf("rand%0d", it), gnt_d, gnt_d && dc_mem_write,
                  gnt_d ? dc_mem_addr : ic_mem_addr, dc_mem_wdata,
                  int'($urandom_range(1, 5)), rand128());
            if (gnt_d) begin d_pend = 0; just_d = 1; end
            else       begin ic_pend = 0; just_i = 1; end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
